// File: rtl/m_cond_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | m_cond_issue_ctrl : issue-stage holding register that resolves e_cond    |
// | codes against NZCV once all in-flight flag writers retire.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module m_cond_issue_ctrl #(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_cond,
   input  logic             in_sets_flags,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_execute,
   output logic             out_sets_flags,
   input  logic             flag_wr_valid,
   input  logic [3:0]       flag_wr,
   input  logic             flush,
   output logic             fault_nv,
   output logic [CNT_W-1:0] inflight
);

   localparam logic [1:0]       c_st_empty = 2'd0;
   localparam logic [1:0]       c_st_wait  = 2'd1;
   localparam logic [1:0]       c_st_valid = 2'd2;
   localparam logic [3:0]       c_cond_al  = 4'hE;
   localparam logic [3:0]       c_cond_nv  = 4'hF;
   localparam logic [CNT_W-1:0] c_max_cnt  = CNT_W'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   logic [1:0]       r_state;
   logic [31:0]      r_instr;
   logic [3:0]       r_cond;
   logic             r_sets;
   logic             r_exec;
   logic [CNT_W-1:0] r_count;
   logic [3:0]       r_flags;
   logic             r_fault;

   logic [1:0]       w_state_nxt;
   logic             w_exec_nxt;
   logic             w_out_valid;
   logic             w_handoff;
   logic             w_in_ready;
   logic             w_capture;
   logic             w_inc;
   logic             w_dec;
   logic             w_cnt_zero;

   // Codes come in complementary pairs: the odd member inverts the even one.
   function automatic logic f_cond_true(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, base;
      {n, z, c, v} = nzcv;
      case (cond[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c & ~z;
         3'd5:    base = ~(n ^ v);
         3'd6:    base = ~z & ~(n ^ v);
         default: base = 1'b1;
      endcase
      return base ^ cond[0];
   endfunction

   assign w_cnt_zero  = (r_count == '0);
   // An executed flag-setter may not leave while the writer window is full,
   // unless a retire frees a slot in the same cycle.
   assign w_out_valid = (r_state == c_st_valid) &&
                        !(r_exec && r_sets && (r_count == c_max_cnt) && !flag_wr_valid);
   assign w_handoff   = w_out_valid && out_ready;
   assign w_in_ready  = !reset && !flush && ((r_state == c_st_empty) || w_handoff);
   assign w_capture   = in_valid && w_in_ready;
   assign w_inc       = w_handoff && r_sets && r_exec;
   assign w_dec       = flag_wr_valid && !w_cnt_zero;

   always_comb begin
      w_state_nxt = r_state;
      w_exec_nxt  = r_exec;
      if (flush) begin
         w_state_nxt = c_st_empty;
      end else if (w_capture) begin
         if (in_cond == c_cond_al) begin
            w_state_nxt = c_st_valid;
            w_exec_nxt  = 1'b1;
         end else if (in_cond == c_cond_nv) begin
            w_state_nxt = c_st_valid;
            w_exec_nxt  = 1'b0;
         end else if (w_cnt_zero && !w_inc) begin
            w_state_nxt = c_st_valid;
            w_exec_nxt  = f_cond_true(in_cond, r_flags);
         end else begin
            w_state_nxt = c_st_wait;
            w_exec_nxt  = 1'b0;
         end
      end else if (w_handoff) begin
         w_state_nxt = c_st_empty;
      end else if ((r_state == c_st_wait) && w_cnt_zero) begin
         w_state_nxt = c_st_valid;
         w_exec_nxt  = f_cond_true(r_cond, r_flags);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_st_empty;
         r_instr <= '0;
         r_cond  <= '0;
         r_sets  <= 1'b0;
         r_exec  <= 1'b0;
         r_count <= '0;
         r_flags <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_exec  <= w_exec_nxt;
         if (w_capture) begin
            r_instr <= in_instr;
            r_cond  <= in_cond;
            r_sets  <= in_sets_flags;
         end
         r_fault <= w_capture && (in_cond == c_cond_nv);
         if (flag_wr_valid) begin
            r_flags <= flag_wr;
         end
         if (w_inc && !w_dec) begin
            r_count <= r_count + c_cnt_one;
         end else if (w_dec && !w_inc) begin
            r_count <= r_count - c_cnt_one;
         end
      end
   end

   assign in_ready       = w_in_ready;
   assign out_valid      = w_out_valid;
   assign out_instr      = r_instr;
   assign out_execute    = r_exec;
   assign out_sets_flags = r_sets & r_exec;
   assign fault_nv       = r_fault;
   assign inflight       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_m_cond_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_m_cond_issue_ctrl : self-checking bench for m_cond_issue_ctrl.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_m_cond_issue_ctrl;

   localparam int MAX_INFLIGHT = 4;
   localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_cond;
   logic             in_sets_flags;
   logic [31:0]      in_instr;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic             out_execute;
   logic             out_sets_flags;
   logic             flag_wr_valid;
   logic [3:0]       flag_wr;
   logic             flush;
   logic             fault_nv;
   logic [CNT_W-1:0] inflight;

   typedef struct packed {
      logic [3:0]  cond;
      logic        sets;
      logic [31:0] instr;
   } item_t;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [3:0] model_flags;
   item_t      q[$];
   int         pending;
   logic       exp_fault;

   m_cond_issue_ctrl #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_cond        (in_cond),
      .in_sets_flags  (in_sets_flags),
      .in_instr       (in_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_execute    (out_execute),
      .out_sets_flags (out_sets_flags),
      .flag_wr_valid  (flag_wr_valid),
      .flag_wr        (flag_wr),
      .flush          (flush),
      .fault_nv       (fault_nv),
      .inflight       (inflight)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference truth table, written straight from the condition definitions.
   function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c)
         4'h0:    return z;
         4'h1:    return !z;
         4'h2:    return cf;
         4'h3:    return !cf;
         4'h4:    return n;
         4'h5:    return !n;
         4'h6:    return v;
         4'h7:    return !v;
         4'h8:    return cf && !z;
         4'h9:    return !cf || z;
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return !z && (n == v);
         4'hD:    return z || (n != v);
         4'hE:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic eq_round(input logic [3:0] wr, input logic sets, input logic [31:0] tag);
      logic e;
      e = cond_true(4'h0, wr);
      in_valid = 1'b1; in_cond = 4'hE; in_sets_flags = 1'b1; in_instr = 32'hA000_0000 | tag;
      @(negedge clk);
      in_cond = 4'h0; in_sets_flags = sets; in_instr = 32'hB000_0000 | tag;
      #1;
      chk("eq_writer_valid", out_valid, 1);
      chk("eq_writer_sets", out_sets_flags, 1);
      chk("eq_capture_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("eq_wait_valid", out_valid, 0);
      chk("eq_wait_inflight", inflight, 1);
      @(negedge clk);
      #1;
      chk("eq_wait2_valid", out_valid, 0);
      @(negedge clk);
      flag_wr_valid = 1'b1; flag_wr = wr; model_flags = wr;
      #1;
      chk("eq_retire_valid", out_valid, 0);
      @(negedge clk);
      flag_wr_valid = 1'b0;
      #1;
      chk("eq_cnt_zero_inflight", inflight, 0);
      chk("eq_cnt_zero_valid", out_valid, 0);
      @(negedge clk);
      #1;
      chk("eq_resolved_valid", out_valid, 1);
      chk("eq_resolved_exec", out_execute, e);
      chk("eq_resolved_sets", out_sets_flags, sets && e);
      chk("eq_resolved_instr", out_instr, 32'hB000_0000 | tag);
      @(negedge clk);
      #1;
      chk("eq_done_valid", out_valid, 0);
      chk("eq_done_inflight", inflight, 0);
   endtask

   task automatic rnd_step(input logic allow_in, input int rdy_pct, input int wr_pct);
      item_t it;
      logic  ho, cap, e;
      int    inc, dec;
      in_valid      = allow_in && ($urandom_range(99) < 60);
      in_cond       = 4'($urandom);
      in_sets_flags = 1'($urandom);
      in_instr      = $urandom;
      out_ready     = ($urandom_range(99) < rdy_pct);
      flag_wr_valid = (pending > 0) && ($urandom_range(99) < wr_pct);
      flag_wr       = 4'($urandom);
      #1;
      chk("rnd_fault_nv", fault_nv, exp_fault);
      chk("rnd_inflight", inflight, pending);
      ho  = out_valid && out_ready;
      cap = in_valid && in_ready;
      inc = 0;
      dec = 0;
      if (ho) begin
         chk("rnd_occupancy", 32'(q.size()), 1);
         if (q.size() > 0) begin
            it = q.pop_front();
            e  = cond_true(it.cond, model_flags);
            chk("rnd_instr", out_instr, it.instr);
            chk("rnd_exec", out_execute, e);
            chk("rnd_sets", out_sets_flags, it.sets && e);
            if (it.sets && e) inc = 1;
         end
      end
      if (flag_wr_valid) begin
         model_flags = flag_wr;
         dec = 1;
      end
      pending   = pending + inc - dec;
      exp_fault = cap && (in_cond == 4'hF);
      if (cap) q.push_back('{cond: in_cond, sets: in_sets_flags, instr: in_instr});
      chk("rnd_depth", 32'(q.size() <= 1), 1);
      @(negedge clk);
   endtask

   initial begin
      logic [3:0]  c, prev_c;
      logic [31:0] prev_instr;
      int          off;

      reset = 1'b1; in_valid = 1'b0; in_cond = '0; in_sets_flags = 1'b0; in_instr = '0;
      out_ready = 1'b0; flag_wr_valid = 1'b0; flag_wr = '0; flush = 1'b0;
      model_flags = '0; pending = 0; exp_fault = 1'b0;
      prev_c = '0; prev_instr = '0;

      @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_execute", out_execute, 0);
      chk("rst_out_sets", out_sets_flags, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_fault_nv", fault_nv, 0);
      chk("rst_inflight", inflight, 0);

      // Plain AL, no flag write.
      @(negedge clk);
      reset = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_cond = 4'hE; in_sets_flags = 1'b0; in_instr = 32'h1234_5678;
      #1;
      chk("al_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("al_out_valid", out_valid, 1);
      chk("al_exec", out_execute, 1);
      chk("al_instr", out_instr, 32'h1234_5678);
      chk("al_sets", out_sets_flags, 0);
      chk("al_inflight", inflight, 0);
      @(negedge clk);
      #1;
      chk("al_done_valid", out_valid, 0);
      chk("al_done_inflight", inflight, 0);

      // EQ waiting on an in-flight writer.
      @(negedge clk);
      eq_round(4'b0100, 1'b0, 32'h1);
      @(negedge clk);
      eq_round(4'b0000, 1'b1, 32'h2);

      // NV capture.
      @(negedge clk);
      in_valid = 1'b1; in_cond = 4'hF; in_sets_flags = 1'b1; in_instr = 32'hDEAD_0001;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("nv_fault", fault_nv, 1);
      chk("nv_valid", out_valid, 1);
      chk("nv_exec", out_execute, 0);
      chk("nv_sets", out_sets_flags, 0);
      chk("nv_inflight", inflight, 0);
      @(negedge clk);
      #1;
      chk("nv_fault_gone", fault_nv, 0);
      chk("nv_done_valid", out_valid, 0);

      // Fill the writer window, then release the fifth setter with a retire.
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_cond = 4'hE; in_sets_flags = 1'b1; in_instr = 32'hC000_0000 + i;
         #1;
         chk("max_in_ready", in_ready, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      chk("max_inflight", inflight, 4);
      chk("max_out_valid", out_valid, 0);
      chk("max_in_ready_low", in_ready, 0);
      @(negedge clk);
      #1;
      chk("max_hold_valid", out_valid, 0);
      flag_wr_valid = 1'b1; flag_wr = 4'b1010; model_flags = 4'b1010;
      #1;
      chk("max_release_valid", out_valid, 1);
      chk("max_release_instr", out_instr, 32'hC000_0004);
      @(negedge clk);
      flag_wr_valid = 1'b0;
      #1;
      chk("max_after_inflight", inflight, 4);
      chk("max_after_valid", out_valid, 0);
      for (int i = 0; i < 4; i++) begin
         flag_wr_valid = 1'b1; flag_wr = 4'($urandom); model_flags = flag_wr;
         @(negedge clk);
      end
      flag_wr_valid = 1'b0;
      #1;
      chk("max_drained_inflight", inflight, 0);

      // Backpressure, then flush.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_cond = 4'hE; in_sets_flags = 1'b0; in_instr = 32'hD0D0_D0D0;
      @(negedge clk);
      in_instr = 32'h0BAD_0BAD;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_instr", out_instr, 32'hD0D0_D0D0);
         chk("stall_exec", out_execute, 1);
         chk("stall_in_ready", in_ready, 0);
         @(negedge clk);
         #1;
      end
      flush = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_inflight", inflight, 0);
      chk("flush_empty_ready", in_ready, 1);

      // Flush coinciding with a handoff: the handoff still counts.
      out_ready = 1'b1;
      in_valid = 1'b1; in_cond = 4'hE; in_sets_flags = 1'b1; in_instr = 32'hE1E1_E1E1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b1;
      #1;
      chk("fh_valid", out_valid, 1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("fh_inflight", inflight, 1);
      chk("fh_out_valid", out_valid, 0);
      flag_wr_valid = 1'b1; flag_wr = 4'($urandom); model_flags = flag_wr;
      @(negedge clk);
      flag_wr_valid = 1'b0;
      #1;
      chk("fh_drained", inflight, 0);

      // Condition sweep: every flag value against codes 0..D.
      @(negedge clk);
      for (int f = 0; f < 16; f++) begin
         flag_wr_valid = 1'b1; flag_wr = f[3:0]; model_flags = f[3:0]; in_valid = 1'b0;
         @(negedge clk);
         flag_wr_valid = 1'b0;
         off = $urandom_range(13);
         for (int k = 0; k < 14; k++) begin
            c = 4'((k + off) % 14);
            in_valid = 1'b1; in_cond = c; in_sets_flags = 1'b0; in_instr = $urandom;
            #1;
            if (k > 0) begin
               chk("sweep_valid", out_valid, 1);
               chk("sweep_exec", out_execute, cond_true(prev_c, model_flags));
               chk("sweep_instr", out_instr, prev_instr);
            end
            prev_c = c;
            prev_instr = in_instr;
            @(negedge clk);
         end
         in_valid = 1'b0;
         #1;
         chk("sweep_last_exec", out_execute, cond_true(prev_c, model_flags));
         @(negedge clk);
      end

      // Randomised mixed traffic against the transaction-level model.
      exp_fault = 1'b0;
      for (int i = 0; i < 600; i++) begin
         rnd_step(1'b1, 75, 35);
      end
      for (int d = 0; d < 80 && (q.size() > 0 || pending > 0); d++) begin
         rnd_step(1'b0, 100, 100);
      end
      #1;
      chk("drain_queue", 32'(q.size()), 0);
      chk("drain_inflight", inflight, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/m_cond_issue_ctrl.md
Name: m_cond_issue_ctrl

Overview:
- Issue-stage controller between the decoder and execute. Accepts decoded instructions carrying an e_cond code and a sets-flags bit.
- Keeps the architectural NZCV flags and a counter of in-flight flag writers. Stalls conditional instructions until all pending flag writes retire, then resolves each instruction to execute or annul.
- Single holding-register stage with valid/ready handshakes on both sides.

Parameters:
- MAX_INFLIGHT, 4, maximum executed flag-setting instructions outstanding downstream.
- CNT_W, $clog2(MAX_INFLIGHT+1), width of the in-flight counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoder has an instruction
- in_ready  out  1  block accepts this cycle
- in_cond  in  4  e_cond: EQ=0 NE=1 CS=2 CC=3 MI=4 PL=5 VS=6 VC=7 HI=8 LS=9 GE=A LT=B GT=C LE=D AL=E NV=F
- in_sets_flags  in  1  instruction writes NZCV
- in_instr  in  32  instruction word, passed through
- out_valid  out  1  resolved instruction available
- out_ready  in  1  execute accepts
- out_instr  out  32  held instruction word
- out_execute  out  1  1 = execute, 0 = annul (treat as nop)
- out_sets_flags  out  1  in_sets_flags AND out_execute
- flag_wr_valid  in  1  execute retires a flag write
- flag_wr  in  4  {N,Z,C,V} written value
- flush  in  1  discard held instruction
- fault_nv  out  1  one-cycle pulse when an NV instruction is captured
- inflight  out  CNT_W  current in-flight counter

Behaviour:
- Reset (one clock, synchronous) sets:
  - state=EMPTY, count=0, flags=0000;
  - out_valid=0, out_execute=0, out_sets_flags=0, out_instr=0, fault_nv=0, inflight=0;
  - in_ready=0 while reset is high.
- States:
  - EMPTY: no instruction held.
  - WAIT: conditional instruction held, flags unresolved.
  - VALID: resolved instruction held.
- Input handshake:
  - in_ready = !flush && (EMPTY || (VALID && out_valid && out_ready)).
  - Capture occurs on in_valid && in_ready.
- Resolution at capture, into the next state:
  - AL: VALID, execute=1.
  - NV: VALID, execute=0; fault_nv pulses in the cycle after capture.
  - Other codes with count==0 and no increment this cycle: evaluate against the flags register; VALID, execute=result.
  - Otherwise: WAIT.
- WAIT: in any cycle with count==0, evaluate against the flags register and go to VALID next cycle. Minimum latency is one cycle after the final flag write is absorbed.
- Condition evaluation:
  - EQ Z, NE !Z; CS C, CC !C; MI N, PL !N; VS V, VC !V.
  - HI C&!Z, LS !C|Z; GE N==V, LT N!=V.
  - GT !Z&(N==V), LE Z|(N!=V).
- Output:
  - out_valid = VALID && !(execute && sets_flags && count==MAX_INFLIGHT && !flag_wr_valid).
  - Handoff occurs on out_valid && out_ready. After handoff: capture → new state, else EMPTY.
  - Payload is stable while out_valid && !out_ready.
- Counter and flags:
  - +1 on a handoff with out_sets_flags=1; -1 on flag_wr_valid; both in the same cycle → unchanged.
  - flag_wr_valid with count==0: count stays 0, flags still updated.
  - The flags register loads flag_wr the cycle after flag_wr_valid.
- Latency: capture at cycle c gives out_valid at c+1 for AL, NV, or a conditional resolvable with count==0.
- Flush:
  - Held instruction dropped; state=EMPTY next cycle; no capture that cycle.
  - count and flags are unaffected, because in-flight writers still retire.
  - Flush has priority over handoff only if out_ready is low. A handoff in the same cycle completes and is counted.
- Reset mid-operation: held instruction is lost, count=0, flags=0000; late flag_wr_valid is handled by the count==0 rule.

Test Plan:
- Reset, then AL, in_sets_flags=0, instr=0x12345678, out_ready=1 → out_valid at c+1, out_execute=1, inflight stays 0.
- AL with sets_flags handed off, then EQ captured → WAIT. flag_wr=0100 (Z=1) two cycles later → inflight 1→0; EQ out_valid one cycle after count==0 with out_execute=1. Repeat with flag_wr=0000 → out_execute=0, out_sets_flags=0.
- NV captured → fault_nv pulse for exactly 1 cycle; out_execute=0; inflight unchanged.
- Hand off 4 executed flag-setters with no retires → inflight=4; 5th flag-setter (AL) held, out_valid=0. flag_wr_valid then releases it in the same cycle and inflight stays 4.
- out_ready=0 while out_valid is high → instr and execute stable for 5 cycles, in_ready=0. Then flush → EMPTY next cycle; inflight unchanged.
- Condition sweep: flags N,Z,C,V set to every one of the 16 values × codes 0–D → out_execute matches the evaluation table. Simultaneous flag_wr_valid and handoff increment → inflight unchanged.
